// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice: FSM encodings
// and default sizing parameters.
package uart_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   localparam int unsigned DEF_N_REQ     = 4;
   localparam int unsigned DEF_MAX_BURST = 16;
   localparam int unsigned DEF_TIMEOUT   = 4096;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first requester found searching
// upward from last_owner+1 with wrap-around wins.
import uart_pkg::*;

module uart_rr_pick #(
   parameter int unsigned N_REQ = DEF_N_REQ,
   parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_owner,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    owner,
   output logic             any
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;

   // Rotate requests so bit k is client (last_owner+1+k) mod N_REQ, then take the lowest set bit
   always_comb begin
      dbl   = {req, req} >> (32'(last_owner) + 32'd1);
      rot   = dbl[N_REQ-1:0];
      any   = 1'b0;
      owner = '0;
      grant = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!any && rot[k]) begin
            any   = 1'b1;
            owner = IW'((32'(last_owner) + 32'd1 + k) % N_REQ);
         end
      end
      if (any) begin
         grant = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ
// clients, with bounded bursts and a tx_done watchdog.
import uart_pkg::*;

module uart_tx_arbiter #(
   parameter int unsigned N_REQ     = DEF_N_REQ,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] data,
   input  logic [N_REQ-1:0]   last,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   input  logic               tx_ready,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_done,
   output logic               busy,
   output logic               timeout_err
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   logic [1:0]       state;
   logic [IW-1:0]    owner;
   logic [IW-1:0]    last_owner;
   logic [7:0]       burst_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic             last_flag;

   logic [N_REQ-1:0] pick_grant;
   logic [IW-1:0]    pick_owner;
   logic             pick_any;

   logic             own_req;
   logic             own_last;
   logic [7:0]       own_lane;
   logic             send_fire;

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .grant      (pick_grant),
      .owner      (pick_owner),
      .any        (pick_any)
   );

   // Owner-lane view and transmitter handshake; a dropped request suppresses the strobe
   always_comb begin
      own_req   = req[owner];
      own_last  = last[owner];
      own_lane  = 8'(data >> (32'(owner) * 32'd8));
      send_fire = (state == ST_SEND) && tx_ready && own_req;
      tx_start  = send_fire;
      ack       = send_fire ? grant : '0;
      tx_data   = (state == ST_SEND) ? own_lane : '0;
      busy      = (state != ST_IDLE);
   end

   // Arbitration FSM: grant, send a byte, wait for the frame to finish or time out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         grant       <= '0;
         owner       <= '0;
         last_owner  <= IW'(N_REQ - 1);
         burst_cnt   <= '0;
         tmo_cnt     <= '0;
         last_flag   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant     <= pick_grant;
                  owner     <= pick_owner;
                  burst_cnt <= '0;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!own_req) begin
                  grant      <= '0;
                  last_owner <= owner;
                  state      <= ST_IDLE;
               end else if (tx_ready) begin
                  last_flag <= own_last;
                  burst_cnt <= burst_cnt + 8'd1;
                  tmo_cnt   <= '0;
                  state     <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  if (last_flag || (burst_cnt == 8'(MAX_BURST)) || !own_req) begin
                     grant      <= '0;
                     last_owner <= owner;
                     state      <= ST_IDLE;
                  end else begin
                     state <= ST_SEND;
                  end
               end else if (tmo_cnt == TW'(TIMEOUT - 2)) begin
                  // Abort on the cycle the counter reaches TIMEOUT-1; it holds there
                  tmo_cnt     <= TW'(TIMEOUT - 1);
                  timeout_err <= 1'b1;
                  grant       <= '0;
                  last_owner  <= owner;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=4, TIMEOUT=16).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  last;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic        tx_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        busy;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ     (4),
      .MAX_BURST (4),
      .TIMEOUT   (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data        (data),
      .last        (last),
      .ack         (ack),
      .grant       (grant),
      .tx_ready    (tx_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic       done;
      logic [3:0] g;
      logic [3:0] ak;
      logic       s;
      logic [7:0] d;
      logic       b;
   } vec_t;

   vec_t vq[$];

   function automatic void add(logic [3:0] r, logic [3:0] l, logic rdy, logic dn,
                               logic [3:0] g, logic [3:0] ak, logic s, logic [7:0] d, logic b);
      vec_t v;
      v.req = r; v.last = l; v.rdy = rdy; v.done = dn;
      v.g = g; v.ak = ak; v.s = s; v.d = d; v.b = b;
      vq.push_back(v);
   endfunction

   function automatic logic [7:0] lane_of(int o);
      logic [31:0] lanes;
      lanes = 32'hA3551C40;
      return lanes[o*8 +: 8];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset;
      rst = 1'b0; req = '0; last = '0; tx_ready = 1'b0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_start(output bit found);
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (tx_start) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_done;
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0; #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int order [6] = '{0, 1, 3, 0, 1, 3};

      data = 32'hA3551C40;
      rst = 1'b0; req = '0; last = '0; tx_ready = 1'b0; tx_done = 1'b0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      rst = 1'b1;

      // Table: single client with tx_done 10 cycles after start, then a req drop in SEND
      add(4'b0100, 4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
      add(4'b0100, 4'b0100, 1, 0, 4'b0100, 4'b0100, 1, 8'h55, 1);
      for (int i = 0; i < 9; i++)
         add(4'b0100, 4'b0100, 1, 0, 4'b0100, 4'b0000, 0, 8'h00, 1);
      add(4'b0100, 4'b0100, 1, 1, 4'b0100, 4'b0000, 0, 8'h00, 1);
      add(4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
      add(4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
      add(4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 8'h40, 1);
      add(4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 8'h40, 1);
      add(4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 8'h00, 0);
      add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         req = vq[i].req; last = vq[i].last; tx_ready = vq[i].rdy; tx_done = vq[i].done;
         #1;
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vq[i].g));
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vq[i].ak));
         chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vq[i].s));
         chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vq[i].d));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].b));
      end
      tx_done = 1'b0;

      // Round-robin: clients 0,1,3 requesting, one byte per grant
      do_reset;
      req = 4'b1011; last = 4'b1111; tx_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_start(found);
         chk($sformatf("rr%0d_found", k), 32'(found), 1);
         chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(1) << order[k]);
         chk($sformatf("rr%0d_ack", k), 32'(ack), 32'(1) << order[k]);
         chk($sformatf("rr%0d_data", k), 32'(tx_data), 32'(lane_of(order[k])));
         pulse_done;
         chk($sformatf("rr%0d_release", k), 32'(grant), 0);
      end

      // Burst cap: client 1 alone, never last, capped at 4 bytes
      do_reset;
      req = 4'b0010; last = 4'b0000; tx_ready = 1'b1;
      wait_start(found);
      chk("burst_found", 32'(found), 1);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("burst%0d_grant", b), 32'(grant), 32'h2);
         chk($sformatf("burst%0d_ack", b), 32'(ack), 32'h2);
         chk($sformatf("burst%0d_data", b), 32'(tx_data), 32'h1C);
         pulse_done;
         if (b < 3) begin
            chk($sformatf("burst%0d_b2b_start", b), 32'(tx_start), 1);
         end else begin
            chk("burst_release_grant", 32'(grant), 0);
            chk("burst_release_busy", 32'(busy), 0);
         end
      end
      @(negedge clk); #1;
      chk("burst_regrant", 32'(grant), 32'h2);
      chk("burst_regrant_start", 32'(tx_start), 1);

      // Backpressure for 20 cycles in SEND, then one start and a timeout
      do_reset;
      req = 4'b0001; last = 4'b0001; tx_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         chk($sformatf("bp%0d_start", i), 32'(tx_start), 0);
         chk($sformatf("bp%0d_ack", i), 32'(ack), 0);
         chk($sformatf("bp%0d_terr", i), 32'(timeout_err), 0);
         chk($sformatf("bp%0d_grant", i), 32'(grant), 32'h1);
      end
      tx_ready = 1'b1; #1;
      chk("bp_start", 32'(tx_start), 1);
      chk("bp_ack", 32'(ack), 32'h1);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk); #1;
         chk($sformatf("tmo%0d_terr", k), 32'(timeout_err), 0);
         chk($sformatf("tmo%0d_start", k), 32'(tx_start), 0);
         chk($sformatf("tmo%0d_grant", k), 32'(grant), 32'h1);
      end
      @(negedge clk); #1;
      chk("tmo_abort_grant", 32'(grant), 0);
      chk("tmo_abort_terr", 32'(timeout_err), 1);
      @(negedge clk); #1;
      chk("tmo_regrant", 32'(grant), 32'h1);
      chk("tmo_regrant_start", 32'(tx_start), 1);
      chk("tmo_sticky1", 32'(timeout_err), 1);
      pulse_done;
      chk("tmo_sticky2", 32'(timeout_err), 1);
      chk("tmo_done_release", 32'(grant), 0);

      // Reset mid-burst, then arbitration restarts from client 0
      do_reset;
      #1;
      chk("rst2_terr_clear", 32'(timeout_err), 0);
      req = 4'b1000; last = 4'b0000; tx_ready = 1'b1;
      wait_start(found);
      chk("rst2_found", 32'(found), 1);
      chk("rst2_grant", 32'(grant), 32'h8);
      @(negedge clk); #1;
      chk("rst2_wait_busy", 32'(busy), 1);
      rst = 1'b0; req = 4'b1001; #1;
      chk("rst2_grant0", 32'(grant), 0);
      chk("rst2_busy0", 32'(busy), 0);
      chk("rst2_start0", 32'(tx_start), 0);
      chk("rst2_ack0", 32'(ack), 0);
      @(negedge clk); rst = 1'b1; #1;
      chk("rst2_rel_start", 32'(tx_start), 0);
      chk("rst2_rel_ack", 32'(ack), 0);
      @(negedge clk); #1;
      chk("rst2_restart_grant", 32'(grant), 32'h1);
      chk("rst2_restart_start", 32'(tx_start), 1);
      chk("rst2_restart_data", 32'(tx_data), 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between N_REQ client requesters using round-robin arbitration with bounded bursts.
- Sequences the transmitter over a tx_ready/tx_start/tx_done handshake.
- Returns a per-client byte acknowledge and flags a stalled transmitter.
- Sits between application byte sources and the serial TX engine, on the same divided-clock domain as the UART receive path.

Parameters:
- N_REQ, 4, number of requesting clients (2..8).
- MAX_BURST, 16, maximum bytes one client sends per grant before forced release (1..255).
- TIMEOUT, 4096, clk cycles allowed between tx_start and tx_done before abort (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous reset, active-low.
- req  input  N_REQ  per-client request; held high while the client has a byte on its data lane.
- data  input  8*N_REQ  per-client byte lanes; client i on bits [8i+7:8i].
- last  input  N_REQ  per-client end-of-packet; sampled with the accepted byte.
- ack  output  N_REQ  one-cycle pulse: client's current byte accepted; client presents the next byte or drops req on the following cycle.
- grant  output  N_REQ  one-hot registered current owner; all zero when idle.
- tx_ready  input  1  transmitter can accept a byte.
- tx_start  output  1  one-cycle strobe loading tx_data into the transmitter.
- tx_data  output  8  byte to transmit; valid while tx_start is high.
- tx_done  input  1  one-cycle pulse: transmitter finished the frame, stop bit included.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky; set on timeout abort, cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; grant=0; ack=0; tx_start=0; tx_data=0; busy=0; timeout_err=0; last_owner=N_REQ-1; burst_cnt=0; tmo_cnt=0.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - If req!=0, select the first requesting client searching upward from last_owner+1 with wrap-around (modulo N_REQ).
  - Register grant = one-hot(selected); burst_cnt=0; go to SEND.
  - Otherwise remain in IDLE.
- SEND:
  - tx_start and ack[owner] are combinational: high exactly when state==SEND and tx_ready==1.
  - tx_data = data lane of owner; drive 0 outside SEND.
  - On tx_start: latch last_flag=last[owner]; burst_cnt+=1; tmo_cnt=0; go to WAIT_DONE.
  - While tx_ready==0, hold SEND with no ack and no timeout counting.
  - If req[owner] drops while in SEND, release: grant=0; last_owner=owner; go to IDLE; no byte is sent.
- WAIT_DONE:
  - Each cycle without tx_done, tmo_cnt+=1.
  - On tx_done, release if last_flag==1, or burst_cnt==MAX_BURST, or req[owner]==0 in the same cycle. Release means grant=0, last_owner=owner, go to IDLE.
  - On tx_done with no release condition, go to SEND, keeping grant.
  - If tmo_cnt reaches TIMEOUT-1 without tx_done: set timeout_err=1; release as above.
- tx_done outside WAIT_DONE is ignored.
- Latency: req rising in IDLE at cycle t gives grant at t+1. tx_start/ack occur at t+1 if tx_ready is high.
- Back-to-back bytes in a burst: tx_done at cycle t gives the next tx_start at t+1 when tx_ready is high.
- Fairness:
  - After release, the released owner has lowest priority in the next arbitration.
  - A single requesting client is re-granted after one IDLE cycle.
- Widths: burst_cnt 8 bits; tmo_cnt = clog2(TIMEOUT) bits, saturating; owner index = clog2(N_REQ) bits.
- Reset asserted mid-burst aborts immediately. No ack or tx_start is generated on the reset-release cycle.

Decomposition:
- Shared package uart_pkg holds:
  - State encodings ST_IDLE=0, ST_SEND=1, ST_WAIT_DONE=2.
  - Default values for MAX_BURST and TIMEOUT.
- One sub-module: uart_rr_pick, a combinational round-robin picker.
  - Inputs: req, last_owner.
  - Outputs: one-hot grant, owner index, any.
  - Instantiated once in IDLE arbitration.

Test Plan:
- Single client: req[2]=1, data lane 2=0x55, last[2]=1, tx_ready=1, tx_done 10 cycles after tx_start. Expect grant=4'b0100 at t+1, tx_start with tx_data=0x55 and ack[2] at t+1, grant=0 after tx_done, busy low next cycle.
- Round-robin: req=4'b1011 held, last=1 for all. Expect grant order client 0,1,3,0,1,3; each grant carries one byte.
- Burst cap: MAX_BURST=4, client 1 req held, last=0. Expect exactly 4 tx_start/ack pairs, then release. Client 1 is re-granted after one IDLE cycle if it is alone.
- Backpressure: tx_ready=0 for 20 cycles in SEND. Expect no tx_start, no ack, timeout_err stays 0. On tx_ready=1, exactly one tx_start.
- Timeout: TIMEOUT=16, tx_done never returned. Expect timeout_err=1 and grant=0 16 cycles after tx_start; timeout_err remains 1 across subsequent grants.
- Reset mid-burst: rst low during WAIT_DONE. Expect grant=0, busy=0, tx_start=0 immediately. After release, arbitration restarts from client 0.
